// File: rtl/filtros_s2_loader_pkg.sv
// Shared constants, FSM state type and counter helper for the stride-2
// filter loader and its convolution read side.
package filtros_pkg;

    localparam int NUM_FILT       = 4;
    localparam int K              = 3;
    localparam int CH             = 3;
    localparam int WORDS_PER_FILT = 27;
    localparam int TOTAL_WORDS    = 108;

    // Largest row/col/channel index and largest filter index.
    localparam logic [1:0] IDX_MAX  = 2'(K - 1);
    localparam logic [1:0] FILT_MAX = 2'(NUM_FILT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        COMMIT = 2'd2
    } loader_state_t;

    // Increment that returns to zero after reaching max.
    function automatic logic [1:0] wrap_inc(input logic [1:0] v, input logic [1:0] max);
        return (v == max) ? 2'd0 : v + 2'd1;
    endfunction

endpackage

// File: rtl/filtros_s2_loader_if.sv
// Valid/ready byte stream carrying convolution weights into the loader.
interface filtros_s2_loader_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] s_data;
    logic             s_valid;
    logic             s_ready;

    modport master (output s_data, output s_valid, input  s_ready);
    modport slave  (input  s_data, input  s_valid, output s_ready);
endinterface

// File: rtl/filtros_s2_loader_idx_counter.sv
// Nested filter/row/col/channel counter. Channel is the fastest digit,
// filter the slowest; last flags the final element (3,2,2,2).
module filtro_idx_counter
    import filtros_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       clr,
    output logic [1:0] f,
    output logic [1:0] row,
    output logic [1:0] col,
    output logic [1:0] ch,
    output logic       last
);
    logic [1:0] f_q, f_d, row_q, row_d, col_q, col_d, ch_q, ch_d;

    // Next-count: clear has priority; each digit carries into the next on wrap.
    always_comb begin
        f_d   = f_q;
        row_d = row_q;
        col_d = col_q;
        ch_d  = ch_q;
        if (clr) begin
            f_d   = '0;
            row_d = '0;
            col_d = '0;
            ch_d  = '0;
        end else if (en) begin
            ch_d = wrap_inc(ch_q, IDX_MAX);
            if (ch_q == IDX_MAX) begin
                col_d = wrap_inc(col_q, IDX_MAX);
                if (col_q == IDX_MAX) begin
                    row_d = wrap_inc(row_q, IDX_MAX);
                    if (row_q == IDX_MAX) begin
                        f_d = wrap_inc(f_q, FILT_MAX);
                    end
                end
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f_q   <= '0;
            row_q <= '0;
            col_q <= '0;
            ch_q  <= '0;
        end else begin
            f_q   <= f_d;
            row_q <= row_d;
            col_q <= col_d;
            ch_q  <= ch_d;
        end
    end

    assign f    = f_q;
    assign row  = row_q;
    assign col  = col_q;
    assign ch   = ch_q;
    assign last = (f_q == FILT_MAX) && (row_q == IDX_MAX) && (col_q == IDX_MAX) && (ch_q == IDX_MAX);

endmodule

// File: rtl/filtros_s2_loader.sv
// Streaming loader for the four stride-2 3x3x3 filters. Words fill a shadow
// bank; the active bank seen by the convolution stage is replaced in one step
// once all 108 words have arrived, so it never shows a half-written set.
module filtros_s2_loader
    import filtros_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic                               abort,
    filtros_s2_loader_if.slave                 s,
    output logic [2:0][2:0][2:0][WIDTH-1:0]    Filtro1,
    output logic [2:0][2:0][2:0][WIDTH-1:0]    Filtro2,
    output logic [2:0][2:0][2:0][WIDTH-1:0]    Filtro3,
    output logic [2:0][2:0][2:0][WIDTH-1:0]    Filtro4,
    output logic                               weights_valid,
    output logic                               busy,
    output logic                               done
);
    typedef logic [2:0][2:0][2:0][WIDTH-1:0] filt_t;
    typedef filt_t [NUM_FILT-1:0]            bank_t;

    loader_state_t state_q, state_d;
    bank_t         shadow_q, shadow_d;
    bank_t         active_q, active_d;
    logic          wvalid_q, wvalid_d;
    logic          s_ready_q, s_ready_d;

    logic [1:0] idx_f, idx_row, idx_col, idx_ch;
    logic       idx_last;
    logic       xfer, cnt_en, cnt_clr, load_last;

    // Abort beats a same-cycle transfer: the word is dropped and nothing commits.
    assign xfer      = s.s_valid && s_ready_q;
    assign cnt_en    = xfer && !abort;
    assign cnt_clr   = (state_q != LOAD) || abort;
    assign load_last = cnt_en && idx_last;

    filtro_idx_counter u_idx (
        .clk  (clk),
        .rst  (rst),
        .en   (cnt_en),
        .clr  (cnt_clr),
        .f    (idx_f),
        .row  (idx_row),
        .col  (idx_col),
        .ch   (idx_ch),
        .last (idx_last)
    );

    // Next-state; s_ready is derived from the next state so it is a pure flop.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start && !abort) state_d = LOAD;
            LOAD:    if (abort)           state_d = IDLE;
                     else if (load_last)  state_d = COMMIT;
            COMMIT:                       state_d = IDLE;
            default:                      state_d = IDLE;
        endcase
        s_ready_d = (state_d == LOAD);
    end

    // Shadow write and commit. The copy is taken on the edge of the final
    // handshake (with that word merged in), so the new set and done are both
    // visible during the COMMIT cycle.
    always_comb begin
        shadow_d = shadow_q;
        active_d = active_q;
        wvalid_d = wvalid_q;
        if (cnt_en) begin
            shadow_d[idx_f][idx_row][idx_col][idx_ch] = s.s_data;
        end
        if (load_last) begin
            active_d = shadow_d;
            wvalid_d = 1'b1;
        end
    end

    // State, handshake and bank registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            s_ready_q <= 1'b0;
            shadow_q  <= '0;
            active_q  <= '0;
            wvalid_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            s_ready_q <= s_ready_d;
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            wvalid_q  <= wvalid_d;
        end
    end

    assign s.s_ready     = s_ready_q;
    assign Filtro1       = active_q[0];
    assign Filtro2       = active_q[1];
    assign Filtro3       = active_q[2];
    assign Filtro4       = active_q[3];
    assign weights_valid = wvalid_q;
    assign busy          = (state_q != IDLE);
    assign done          = (state_q == COMMIT);

endmodule

// File: tb/tb_filtros_s2_loader.sv
// Scoreboard bench for filtros_s2_loader: stimulus records each accepted word
// into a flat 108-entry image and queues it on completion; a monitor checks
// the active bank against the last committed image every cycle.
module tb_filtros_s2_loader;
    import filtros_pkg::*;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst, start, abort;
    logic [2:0][2:0][2:0][W-1:0] f1, f2, f3, f4;
    logic wv, busy_o, done_o;

    filtros_s2_loader_if #(.WIDTH(W)) bus ();

    filtros_s2_loader #(.WIDTH(W)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .abort         (abort),
        .s             (bus.slave),
        .Filtro1       (f1),
        .Filtro2       (f2),
        .Filtro3       (f3),
        .Filtro4       (f4),
        .weights_valid (wv),
        .busy          (busy_o),
        .done          (done_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int dones_seen = 0;
    int dones_exp = 0;
    logic [863:0] exp_q[$];
    logic [863:0] cur_exp = '0;
    logic         cur_valid = 1'b0;

    // Flatten the four DUT filters into stream order n = 27f + 9row + 3col + ch.
    function automatic logic [863:0] pack_dut();
        logic [863:0] v;
        v = '0;
        for (int f = 0; f < 4; f++)
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    for (int k = 0; k < 3; k++) begin
                        int n;
                        n = 27*f + 9*r + 3*c + k;
                        case (f)
                            0: v[n*8 +: 8] = f1[r][c][k];
                            1: v[n*8 +: 8] = f2[r][c][k];
                            2: v[n*8 +: 8] = f3[r][c][k];
                            default: v[n*8 +: 8] = f4[r][c][k];
                        endcase
                    end
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Monitor: done pops the next expected image; the active bank must always
    // equal the most recently committed image.
    always @(negedge clk) begin
        if (rst) begin
            cur_exp   = '0;
            cur_valid = 1'b0;
        end else begin
            if (done_o) begin
                dones_seen++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL done_unexpected actual=1 expected=0");
                end else begin
                    cur_exp = exp_q.pop_front();
                end
                cur_valid = 1'b1;
            end
            checks++;
            if (pack_dut() !== cur_exp || wv !== cur_valid) begin
                errors++;
                $display("FAIL active_bank wv=%0b/%0b actual=%h expected=%h", wv, cur_valid, pack_dut(), cur_exp);
            end
        end
    end

    // One load attempt. mode: 0 -> n, 1 -> 200-n, 2 -> random. abort_at /
    // reset_at / start_at give the handshake count at which to interfere (-1 = never).
    task automatic run_load(input int mode, input int gap_pct, input int abort_at,
                            input int reset_at, input int start_at, output int ready_cycles);
        logic [863:0] img;
        int hs, cyc;
        bit start_sent;
        img = '0; hs = 0; cyc = 0; ready_cycles = 0; start_sent = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while (hs < 108 && cyc < 3000) begin
            if (hs == reset_at) begin
                #2 rst = 1'b1;
                #1;
                chk("rst_bank_zero", 32'(pack_dut() == '0), 1);
                chk("rst_wvalid", wv, 0);
                chk("rst_busy", busy_o, 0);
                chk("rst_ready", bus.s_ready, 0);
                chk("rst_done", done_o, 0);
                @(posedge clk); #1;
                rst = 1'b0;
                bus.s_valid = 1'b0;
                return;
            end
            bus.s_valid = ($urandom_range(99) >= gap_pct);
            case (mode)
                0: bus.s_data = W'(hs);
                1: bus.s_data = W'(200 - hs);
                default: bus.s_data = W'($urandom);
            endcase
            if (hs == start_at && !start_sent) begin
                start = 1'b1;
                start_sent = 1;
            end
            if (hs == abort_at) begin
                abort = 1'b1;
                bus.s_valid = 1'b0;
            end
            @(negedge clk);
            chk("ready_in_load", bus.s_ready, 1);
            if (bus.s_ready) ready_cycles++;
            if (hs == abort_at) begin
                @(posedge clk); #1;
                abort = 1'b0;
                @(negedge clk);
                chk("abort_ready", bus.s_ready, 0);
                chk("abort_busy", busy_o, 0);
                @(posedge clk); #1;
                return;
            end
            if (bus.s_valid && bus.s_ready) begin
                img[hs*8 +: 8] = bus.s_data;
                hs++;
                if (hs == 108) begin
                    exp_q.push_back(img);
                    dones_exp++;
                end
            end
            @(posedge clk); #1;
            start = 1'b0;
            cyc++;
        end
        bus.s_valid = 1'b0;
        start = 1'b0;
        if (hs < 108) begin
            chk("load_timeout", hs, 108);
            return;
        end
        @(negedge clk);
        chk("commit_busy", busy_o, 1);
        chk("commit_ready", bus.s_ready, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("post_busy", busy_o, 0);
        chk("post_done", done_o, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        int rc;
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        bus.s_valid = 1'b0; bus.s_data = '0;
        #1;
        chk("reset_bank_zero", 32'(pack_dut() == '0), 1);
        chk("reset_wvalid", wv, 0);
        chk("reset_busy", busy_o, 0);
        chk("reset_done", done_o, 0);
        chk("reset_ready", bus.s_ready, 0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Full load, no gaps.
        run_load(0, 0, -1, -1, -1, rc);
        chk("ready_cycles", rc, 108);
        chk("f1_000", f1[0][0][0], 0);
        chk("f1_222", f1[2][2][2], 26);
        chk("f2_000", f2[0][0][0], 27);
        chk("f4_120", f4[1][2][0], 96);
        chk("f4_222", f4[2][2][2], 107);
        chk("wvalid_after_load", wv, 1);

        // Reload with 200-n; old set stays visible until the new done.
        run_load(1, 0, -1, -1, -1, rc);
        chk("reload_f1_000", f1[0][0][0], 200);
        chk("reload_f4_222", f4[2][2][2], 93);

        // Gapped load with a stray start part-way through.
        run_load(0, 50, -1, -1, 30, rc);
        chk("gap_f4_222", f4[2][2][2], 107);

        // Abort after 50 words, then a clean random load.
        run_load(2, 20, 50, -1, -1, rc);
        chk("abort_wvalid", wv, 1);
        run_load(2, 30, -1, -1, -1, rc);

        // start together with abort in IDLE.
        start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        @(negedge clk);
        chk("start_abort_busy", busy_o, 0);
        chk("start_abort_ready", bus.s_ready, 0);
        @(posedge clk); #1;

        // Asynchronous reset at word 70, then recovery load.
        run_load(0, 0, -1, 70, -1, rc);
        chk("after_rst_wvalid", wv, 0);
        run_load(2, 40, -1, -1, -1, rc);

        repeat (3) @(posedge clk);
        #1;
        chk("done_count", dones_seen, dones_exp);
        chk("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
